uart_dev: RTL and testbench

- Memory-mapped 8N1 UART peripheral on the Bridge's device side, alongside the two timer instances. Same port style as the timers: word address, write enable, Din/Dout, IRQ.
- Contains a transmit FIFO, a single receive holding register, a programmable baud divisor and a level interrupt.
- IRQ feeds HWInt[3]. RXD/TXD go to the board pins.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_txfifo.sv | 54 +++++
 rtl/uart_dev.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_uart_dev.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STAT/CTRL bit positions, the shared serial FSM
// state encoding and the frame width used by the uart_dev peripheral.
package uart_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_DIV  = 2'd3;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_TX_EMPTY = 2;
    localparam int STAT_OVERRUN  = 3;
    localparam int STAT_TX_BUSY  = 4;
    localparam int STAT_FERR     = 5;

    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;
    localparam int CTRL_LOOPBACK  = 2;

    localparam int FRAME_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_txfifo.sv
// uart_txfifo: small synchronous FIFO with extra-MSB pointers; a pop on the
// same edge as a push frees the slot, so a push into a full FIFO succeeds then.
module uart_txfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             doPush, doPop;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPop   = pop_i & ~empty_o;
    assign doPush  = push_i & (~full_o | doPop);
    assign head_o  = mem_q[rdPtr_q[AW-1:0]];

    // Advance each pointer by one on an accepted push or pop.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
        if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_dev.sv
// uart_dev: memory-mapped 8N1 UART with a TX FIFO, one RX holding register,
// programmable bit divisor and a level interrupt.
// Optional feature: define UART_LOOPBACK_EN to make CTRL[2] loop TX into RX.
module uart_dev
    import uart_pkg::*;
#(
    parameter int          TX_DEPTH    = 4,
    parameter logic [15:0] DIV_DEFAULT = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic        RE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    input  logic        RXD,
    output logic        TXD,
    output logic        IRQ
);

`ifdef UART_LOOPBACK_EN
    localparam logic LOOP_ALLOWED = 1'b1;
`else
    localparam logic LOOP_ALLOWED = 1'b0;
`endif

    localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 1);

    logic [1:0]            regSel;
    logic                  wrData, wrCtrl, wrDiv, rdData, rdStat;
    logic [2:0]            ctrl_q, ctrl_d;
    logic [15:0]           div_q, div_d, bitPeriodLast, halfPeriodLast;
    logic [FRAME_BITS-1:0] rxByte_q, rxByte_d;
    logic                  rxValid_q, rxValid_d, overrun_q, overrun_d, ferr_q, ferr_d;
    logic [5:0]            statBits;
    logic                  unusedBits;

    logic [FRAME_BITS-1:0] fifoHead;
    logic                  fifoFull, fifoEmpty;

    uart_state_e           txState_q, txState_d;
    logic [15:0]           txCnt_q, txCnt_d;
    logic [FRAME_BITS-1:0] txShift_q, txShift_d;
    logic [2:0]            txBit_q, txBit_d;
    logic                  txSerial, txBusy, txPop;

    uart_state_e           rxState_q, rxState_d;
    logic [15:0]           rxCnt_q, rxCnt_d;
    logic [FRAME_BITS-1:0] rxShift_q, rxShift_d;
    logic [2:0]            rxBit_q, rxBit_d;
    logic                  rxLine, rxSync1_q, rxSync2_q, rxPrev_q, rxFall;
    logic                  rxDone, rxBadStop;

    assign regSel         = Addr[3:2];
    assign wrData         = WE && (regSel == REG_DATA);
    assign wrCtrl         = WE && (regSel == REG_CTRL);
    assign wrDiv          = WE && (regSel == REG_DIV);
    assign rdData         = RE && (regSel == REG_DATA);
    assign rdStat         = RE && (regSel == REG_STAT);
    assign bitPeriodLast  = div_q - 16'd1;
    assign halfPeriodLast = {1'b0, div_q[15:1]} - 16'd1;
    assign unusedBits     = ^{Addr[31:4], Din[31:16]};

    uart_txfifo #(.DEPTH(TX_DEPTH), .WIDTH(FRAME_BITS)) uTxFifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (wrData),
        .data_i (Din[FRAME_BITS-1:0]),
        .pop_i  (txPop),
        .head_o (fifoHead),
        .full_o (fifoFull),
        .empty_o(fifoEmpty)
    );

    // TX state register: state, bit-period counter, shift register, bit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txState_q <= ST_IDLE;
            txCnt_q   <= '0;
            txShift_q <= '0;
            txBit_q   <= '0;
        end else begin
            txState_q <= txState_d;
            txCnt_q   <= txCnt_d;
            txShift_q <= txShift_d;
            txBit_q   <= txBit_d;
        end
    end

    // TX next state: each state lasts DIV cycles; DIV is re-read at every bit boundary.
    always_comb begin
        txState_d = txState_q;
        txCnt_d   = txCnt_q;
        txShift_d = txShift_q;
        txBit_d   = txBit_q;
        case (txState_q)
            ST_IDLE: begin
                if (!fifoEmpty) begin
                    txState_d = ST_START;
                    txCnt_d   = bitPeriodLast;
                    txShift_d = fifoHead;
                end
            end
            ST_START: begin
                if (txCnt_q == 16'd0) begin
                    txState_d = ST_DATA;
                    txCnt_d   = bitPeriodLast;
                    txBit_d   = '0;
                end else begin
                    txCnt_d = txCnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (txCnt_q == 16'd0) begin
                    txCnt_d   = bitPeriodLast;
                    txShift_d = {1'b0, txShift_q[FRAME_BITS-1:1]};
                    if (txBit_q == LAST_BIT) txState_d = ST_STOP;
                    else                     txBit_d   = txBit_q + 3'd1;
                end else begin
                    txCnt_d = txCnt_q - 16'd1;
                end
            end
            default: begin
                if (txCnt_q == 16'd0) txState_d = ST_IDLE;
                else                  txCnt_d   = txCnt_q - 16'd1;
            end
        endcase
    end

    // TX outputs: serial bit, busy flag and the FIFO pop taken when leaving IDLE.
    always_comb begin
        txBusy = (txState_q != ST_IDLE);
        txPop  = (txState_q == ST_IDLE) && !fifoEmpty;
        case (txState_q)
            ST_START: txSerial = 1'b0;
            ST_DATA:  txSerial = txShift_q[0];
            default:  txSerial = 1'b1;
        endcase
    end

    assign rxLine = ctrl_q[CTRL_LOOPBACK] ? txSerial : RXD;
    assign TXD    = ctrl_q[CTRL_LOOPBACK] ? 1'b1 : txSerial;
    assign rxFall = rxPrev_q & ~rxSync2_q;

    // RX synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxSync1_q <= 1'b1;
            rxSync2_q <= 1'b1;
            rxPrev_q  <= 1'b1;
        end else begin
            rxSync1_q <= rxLine;
            rxSync2_q <= rxSync1_q;
            rxPrev_q  <= rxSync2_q;
        end
    end

    // RX state register: state, sample counter, shift register, bit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxState_q <= ST_IDLE;
            rxCnt_q   <= '0;
            rxShift_q <= '0;
            rxBit_q   <= '0;
        end else begin
            rxState_q <= rxState_d;
            rxCnt_q   <= rxCnt_d;
            rxShift_q <= rxShift_d;
            rxBit_q   <= rxBit_d;
        end
    end

    // RX next state: half-period start check for glitch rejection, then mid-bit samples.
    always_comb begin
        rxState_d = rxState_q;
        rxCnt_d   = rxCnt_q;
        rxShift_d = rxShift_q;
        rxBit_d   = rxBit_q;
        case (rxState_q)
            ST_IDLE: begin
                if (rxFall) begin
                    rxState_d = ST_START;
                    rxCnt_d   = halfPeriodLast;
                end
            end
            ST_START: begin
                if (rxCnt_q == 16'd0) begin
                    if (!rxSync2_q) begin
                        rxState_d = ST_DATA;
                        rxCnt_d   = bitPeriodLast;
                        rxBit_d   = '0;
                    end else begin
                        rxState_d = ST_IDLE;
                    end
                end else begin
                    rxCnt_d = rxCnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (rxCnt_q == 16'd0) begin
                    rxShift_d = {rxSync2_q, rxShift_q[FRAME_BITS-1:1]};
                    rxCnt_d   = bitPeriodLast;
                    if (rxBit_q == LAST_BIT) rxState_d = ST_STOP;
                    else                     rxBit_d   = rxBit_q + 3'd1;
                end else begin
                    rxCnt_d = rxCnt_q - 16'd1;
                end
            end
            default: begin
                if (rxCnt_q == 16'd0) rxState_d = ST_IDLE;
                else                  rxCnt_d   = rxCnt_q - 16'd1;
            end
        endcase
    end

    // RX outputs: frame-complete and framing-error pulses at the stop-bit sample.
    always_comb begin
        rxDone    = (rxState_q == ST_STOP) && (rxCnt_q == 16'd0) &&  rxSync2_q;
        rxBadStop = (rxState_q == ST_STOP) && (rxCnt_q == 16'd0) && !rxSync2_q;
    end

    // Register-file next state: bus writes, read side-effects and RX status updates.
    always_comb begin
        ctrl_d    = ctrl_q;
        div_d     = div_q;
        rxByte_d  = rxByte_q;
        rxValid_d = rxValid_q;
        overrun_d = overrun_q;
        ferr_d    = ferr_q;
        if (wrCtrl) ctrl_d = {Din[2] & LOOP_ALLOWED, Din[1:0]};
        if (wrDiv)  div_d  = (Din[15:0] < 16'd2) ? 16'd2 : Din[15:0];
        if (rdStat) begin
            overrun_d = 1'b0;
            ferr_d    = 1'b0;
        end
        if (rdData) rxValid_d = 1'b0;
        if (rxDone) begin
            if (!rxValid_q || rdData) begin
                rxByte_d  = rxShift_q;
                rxValid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (rxBadStop) ferr_d = 1'b1;
    end

    // Register-file storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q    <= '0;
            div_q     <= DIV_DEFAULT;
            rxByte_q  <= '0;
            rxValid_q <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            div_q     <= div_d;
            rxByte_q  <= rxByte_d;
            rxValid_q <= rxValid_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    // Read mux, combinational from Addr so data is valid in the strobe cycle.
    always_comb begin
        statBits                = '0;
        statBits[STAT_RX_VALID] = rxValid_q;
        statBits[STAT_TX_FULL]  = fifoFull;
        statBits[STAT_TX_EMPTY] = fifoEmpty;
        statBits[STAT_OVERRUN]  = overrun_q;
        statBits[STAT_TX_BUSY]  = txBusy;
        statBits[STAT_FERR]     = ferr_q;
        case (regSel)
            REG_DATA: Dout = {24'b0, rxByte_q};
            REG_STAT: Dout = {26'b0, statBits};
            REG_CTRL: Dout = {29'b0, ctrl_q};
            default:  Dout = {16'b0, div_q};
        endcase
    end

    assign IRQ = (ctrl_q[CTRL_RX_IRQ_EN] & rxValid_q) |
                 (ctrl_q[CTRL_TX_IRQ_EN] & fifoEmpty & ~txBusy);

endmodule

// File: tb/tb_uart_dev.sv
// tb_uart_dev: scoreboard bench for uart_dev. TX bytes are queued when written
// and compared when a frame is decoded from TXD; RX bytes are queued when a
// frame is driven on RXD and compared when DATA is read back.
module tb_uart_dev;
    import uart_pkg::*;

    localparam int          TX_DEPTH    = 4;
    localparam logic [15:0] DIV_DEFAULT = 16'd434;

    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic        RE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        RXD;
    logic        TXD;
    logic        IRQ;

    int   total = 0;
    int   bad = 0;
    int   tbDiv = 4;
    logic monEnable = 1'b0;
    logic [7:0] txExp [$];
    logic [7:0] rxExp [$];

    uart_dev #(.TX_DEPTH(TX_DEPTH), .DIV_DEFAULT(DIV_DEFAULT)) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .RE   (RE),
        .Din  (Din),
        .Dout (Dout),
        .RXD  (RXD),
        .TXD  (TXD),
        .IRQ  (IRQ)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something never finishes.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, actual, expected);
        end
    endtask

    // Bus write; call at a negedge, returns at the next negedge.
    task automatic applyStimulus(input logic [1:0] off, input logic [31:0] data);
        Addr      = '0;
        Addr[3:2] = off;
        Din       = data;
        WE        = 1'b1;
        @(negedge clk);
        WE = 1'b0;
    endtask

    // Bus read; call at a negedge, samples Dout combinationally, returns at the next negedge.
    task automatic busRead(input logic [1:0] off, input logic re, output logic [31:0] data);
        Addr      = '0;
        Addr[3:2] = off;
        RE        = re;
        #1;
        data = Dout;
        @(negedge clk);
        RE = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [1:0] off, input logic [31:0] expected);
        logic [31:0] d;
        busRead(off, 1'b0, d);
        checkOutput(tag, d, expected);
    endtask

    task automatic txSend(input logic [7:0] b, input logic accepted);
        applyStimulus(REG_DATA, {24'b0, b});
        if (accepted) txExp.push_back(b);
    endtask

    task automatic waitTxDrain();
        for (int i = 0; i < 3000 && txExp.size() != 0; i++) @(negedge clk);
        checkOutput("tx-drain", 32'(txExp.size()), 32'd0);
        repeat (tbDiv + 4) @(negedge clk);
    endtask

    // Drive one serial frame on RXD at tbDiv cycles per bit, followed by an idle bit time.
    task automatic rxSendFrame(input logic [7:0] b, input logic stopBit);
        RXD = 1'b0;
        repeat (tbDiv) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (tbDiv) @(negedge clk);
        end
        RXD = stopBit;
        repeat (tbDiv) @(negedge clk);
        RXD = 1'b1;
        repeat (tbDiv) @(negedge clk);
    endtask

    task automatic waitRxValid(input string tag);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 200; i++) begin
            busRead(REG_STAT, 1'b0, s);
            if (s[STAT_RX_VALID]) break;
        end
        checkOutput(tag, {31'b0, s[STAT_RX_VALID]}, 32'd1);
    endtask

    task automatic rxReadData(input string tag);
        logic [31:0] d;
        busRead(REG_DATA, 1'b1, d);
        checkOutput("rx-queue", {31'b0, rxExp.size() != 0}, 32'd1);
        if (rxExp.size() != 0) checkOutput(tag, d, {24'b0, rxExp.pop_front()});
    endtask

    // TXD decoder: samples 1.5 cycles into each bit and pops the expected byte.
    initial begin : txMonitor
        logic [7:0] got;
        got = '0;
        forever begin
            @(negedge clk);
            if (monEnable && reset === 1'b1 && TXD === 1'b0) begin
                @(negedge clk);
                checkOutput("tx-start", {31'b0, TXD}, 32'd0);
                for (int b = 0; b < 8; b++) begin
                    repeat (tbDiv) @(negedge clk);
                    got[b] = TXD;
                end
                repeat (tbDiv) @(negedge clk);
                checkOutput("tx-stop", {31'b0, TXD}, 32'd1);
                checkOutput("tx-expected", {31'b0, txExp.size() != 0}, 32'd1);
                if (txExp.size() != 0) checkOutput("tx-byte", {24'b0, got}, {24'b0, txExp.pop_front()});
            end
        end
    end

    // Main sequence.
    initial begin
        logic [31:0] d;
        int lows;
        reset = 1'b0;
        Addr  = '0;
        WE    = 1'b0;
        RE    = 1'b0;
        Din   = '0;
        RXD   = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst-txd", {31'b0, TXD}, 32'd1);
        checkOutput("rst-irq", {31'b0, IRQ}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        readCheck("rst-stat", REG_STAT, 32'h04);
        readCheck("rst-ctrl", REG_CTRL, 32'h0);
        readCheck("rst-div",  REG_DIV,  {16'b0, DIV_DEFAULT});
        readCheck("rst-data", REG_DATA, 32'h0);

        applyStimulus(REG_DIV, 32'h0000_0000);
        readCheck("div-floor0", REG_DIV, 32'd2);
        applyStimulus(REG_DIV, 32'hFFFF_0001);
        readCheck("div-floor1", REG_DIV, 32'd2);
        applyStimulus(REG_DIV, 32'h0000_0004);
        tbDiv = 4;
        readCheck("div-set", REG_DIV, 32'd4);

        applyStimulus(REG_CTRL, 32'hFFFF_FFFA);
        readCheck("ctrl-wr", REG_CTRL, 32'h2);
        checkOutput("irq-txidle", {31'b0, IRQ}, 32'd1);
        applyStimulus(REG_CTRL, 32'h0000_0007);
`ifdef UART_LOOPBACK_EN
        readCheck("ctrl-loopbit", REG_CTRL, 32'h7);
`else
        readCheck("ctrl-loopbit", REG_CTRL, 32'h3);
`endif
        applyStimulus(REG_CTRL, 32'h0);
        checkOutput("irq-off", {31'b0, IRQ}, 32'd0);

        monEnable = 1'b1;
        txSend(8'h55, 1'b1);
        repeat (40) @(negedge clk);
        readCheck("tx1-busy-last", REG_STAT, 32'h14);
        readCheck("tx1-idle", REG_STAT, 32'h04);
        waitTxDrain();

        txSend(8'h00, 1'b1);
        for (int i = 1; i <= 4; i++) txSend(8'(i), 1'b1);
        readCheck("tx2-full", REG_STAT, 32'h12);
        txSend(8'h05, 1'b0);
        txSend(8'h06, 1'b0);
        readCheck("tx2-still-full", REG_STAT, 32'h12);
        waitTxDrain();
        repeat (20) @(negedge clk);
        readCheck("tx2-idle", REG_STAT, 32'h04);

        applyStimulus(REG_DIV, 32'd8);
        tbDiv = 8;
        rxExp.push_back(8'hA3);
        rxSendFrame(8'hA3, 1'b1);
        waitRxValid("rx1-arrive");
        readCheck("rx1-stat", REG_STAT, 32'h05);
        applyStimulus(REG_CTRL, 32'h1);
        checkOutput("rx1-irq", {31'b0, IRQ}, 32'd1);
        rxReadData("rx1-byte");
        checkOutput("rx1-irq-clr", {31'b0, IRQ}, 32'd0);
        readCheck("rx1-stat-clr", REG_STAT, 32'h04);

        rxExp.push_back(8'h11);
        rxSendFrame(8'h11, 1'b1);
        rxSendFrame(8'h22, 1'b1);
        readCheck("rx2-overrun", REG_STAT, 32'h0D);
        checkOutput("rx2-irq", {31'b0, IRQ}, 32'd1);
        busRead(REG_STAT, 1'b1, d);
        checkOutput("rx2-stat-re", d, 32'h0D);
        readCheck("rx2-overrun-clr", REG_STAT, 32'h05);
        rxReadData("rx2-first-kept");
        rxSendFrame(8'h5A, 1'b0);
        readCheck("rx3-ferr", REG_STAT, 32'h24);
        checkOutput("rx3-irq", {31'b0, IRQ}, 32'd0);
        busRead(REG_STAT, 1'b1, d);
        readCheck("rx3-ferr-clr", REG_STAT, 32'h04);

        applyStimulus(REG_DIV, 32'd4);
        tbDiv = 4;
        monEnable = 1'b0;
        applyStimulus(REG_DATA, 32'hF0);
        repeat (17) @(negedge clk);
        checkOutput("rst-bit3-low", {31'b0, TXD}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst-async-txd", {31'b0, TXD}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        readCheck("rst2-stat", REG_STAT, 32'h04);
        readCheck("rst2-div", REG_DIV, {16'b0, DIV_DEFAULT});
        readCheck("rst2-ctrl", REG_CTRL, 32'h0);
        checkOutput("rst2-irq", {31'b0, IRQ}, 32'd0);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (TXD !== 1'b1) lows++;
        end
        checkOutput("rst2-txd-idle", 32'(lows), 32'd0);

`ifdef UART_LOOPBACK_EN
        applyStimulus(REG_DIV, 32'd4);
        tbDiv = 4;
        monEnable = 1'b1;
        applyStimulus(REG_CTRL, 32'h5);
        rxExp.push_back(8'h3C);
        applyStimulus(REG_DATA, 32'h3C);
        lows = 0;
        d = '0;
        for (int i = 0; i < 200; i++) begin
            if (TXD !== 1'b1) lows++;
            busRead(REG_STAT, 1'b0, d);
            if (d[STAT_RX_VALID]) break;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (TXD !== 1'b1) lows++;
        end
        checkOutput("lb-arrive", {31'b0, d[STAT_RX_VALID]}, 32'd1);
        checkOutput("lb-txd-high", 32'(lows), 32'd0);
        checkOutput("lb-irq", {31'b0, IRQ}, 32'd1);
        rxReadData("lb-byte");
`endif

        checkOutput("tx-pending", 32'(txExp.size()), 32'd0);
        checkOutput("rx-pending", 32'(rxExp.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
